// File: rtl/generator_pkg.sv
// Shared widths and FSM state type for the phase accumulator / address generator.
// ADDR_WIDTH has to stay equal to the address width of the downstream wavetable memory.
package generator_pkg;

  localparam int ACC_WIDTH  = 32;
  localparam int ADDR_WIDTH = 12;
  localparam int DIV_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/phase_address_gen_tick_divider.sv
// Programmable tick divider: one tick every rate_div+1 enabled cycles.
// The count is cleared by a phase sync so the very next enabled cycle ticks.
module tick_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_sync,
  input  logic [DIV_WIDTH-1:0] i_rate_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 w_tick;

  assign w_tick = i_enable && (r_div_cnt == '0);
  assign o_tick = w_tick;

  // rate_div is only sampled when the count reloads, so mid-period changes wait for the next tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
    end else if (i_sync) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= i_rate_div;
    end else if (i_enable) begin
      r_div_cnt <= r_div_cnt - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/phase_address_gen.sv
// Phase accumulator feeding the wavetable memory address; tuning-word updates are
// deferred to a tick boundary so the generated phase never jumps mid-period.
module phase_address_gen #(
  parameter int ACC_WIDTH  = generator_pkg::ACC_WIDTH,
  parameter int ADDR_WIDTH = generator_pkg::ADDR_WIDTH,
  parameter int DIV_WIDTH  = generator_pkg::DIV_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [ACC_WIDTH-1:0]  i_freq_word,
  input  logic                  i_freq_valid,
  output logic                  o_freq_ready,
  input  logic [ADDR_WIDTH-1:0] i_phase_offset,
  input  logic [DIV_WIDTH-1:0]  i_rate_div,
  input  logic                  i_sync,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_addr_valid,
  output logic                  o_wrap
);

  import generator_pkg::*;

  state_t                r_state;
  state_t                w_state_next;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_inc;
  logic [ACC_WIDTH-1:0]  r_shadow;
  logic [ADDR_WIDTH-1:0] r_address;
  logic                  r_addr_valid;
  logic                  r_wrap;

  logic                  w_tick;
  logic                  w_handshake;
  logic                  w_load_inc;
  logic                  w_load_shadow;
  logic                  w_apply;
  logic [ACC_WIDTH-1:0]  w_inc_used;
  logic [ACC_WIDTH-1:0]  w_acc_next;
  logic                  w_carry;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  tick_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_divider (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .i_sync     (i_sync),
    .i_rate_div (i_rate_div),
    .o_tick     (w_tick)
  );

  assign o_freq_ready = (r_state != PEND);
  assign w_handshake  = i_freq_valid && o_freq_ready;

  // The applying tick in PEND already advances by the new word
  assign w_inc_used = (r_state == PEND) ? r_shadow : r_inc;
  assign {w_carry, w_acc_next} = {1'b0, r_acc} + {1'b0, w_inc_used};
  assign w_addr_next = w_acc_next[ACC_WIDTH-1 -: ADDR_WIDTH] + i_phase_offset;

  always_comb begin
    w_state_next  = r_state;
    w_load_inc    = 1'b0;
    w_load_shadow = 1'b0;
    w_apply       = 1'b0;
    case (r_state)
      IDLE: begin
        w_load_inc = w_handshake;
        if (i_enable) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_handshake) begin
          w_load_shadow = 1'b1;
          w_state_next  = PEND;
        end else if (!i_enable) begin
          w_state_next = IDLE;
        end
      end
      PEND: begin
        // A pending word survives enable dropping and lands on the first tick afterwards
        if (w_tick) begin
          w_apply      = 1'b1;
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_inc    <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_inc) begin
        r_inc <= i_freq_word;
      end
      if (w_load_shadow) begin
        r_shadow <= i_freq_word;
      end
      if (w_apply) begin
        r_inc <= r_shadow;
      end
    end
  end

  // Sync wins over a coincident tick: phase restarts at zero with no increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc        <= '0;
      r_address    <= '0;
      r_addr_valid <= 1'b0;
      r_wrap       <= 1'b0;
    end else if (i_sync) begin
      r_acc        <= '0;
      r_address    <= i_phase_offset;
      r_addr_valid <= 1'b1;
      r_wrap       <= 1'b0;
    end else if (w_tick) begin
      r_acc        <= w_acc_next;
      r_address    <= w_addr_next;
      r_addr_valid <= 1'b1;
      r_wrap       <= w_carry;
    end else begin
      r_addr_valid <= 1'b0;
      r_wrap       <= 1'b0;
    end
  end

  assign o_address    = r_address;
  assign o_addr_valid = r_addr_valid;
  assign o_wrap       = r_wrap;

endmodule
